gen_fip_conv_rr_sched: RTL

- Round-robin scheduler that shares one saturating fixed-point width converter among N_REQ requesters.
- Each requester issues a start pulse with an operand. The block queues one operand per requester, grants the shared converter round-robin, and returns the converted value with a per-requester done pulse.
- Conversion runs in a 3-stage pipeline at 1 result/cycle. The block sits between the filter/accumulator datapaths and narrower fixed-point consumers.

---
 rtl/gen_fip_conv_rr_sched.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/gen_fip_conv_rr_sched.sv
// Round-robin scheduler that shares one saturating fixed-point width converter
// among N_REQ requesters, with a one-operand queue per requester and a 3-stage pipeline.
module gen_fip_conv_rr_sched #(
    parameter int N_REQ           = 4,
    parameter int IN_NUM_INT_W    = 6,
    parameter int IN_NUM_FRACT_W  = 11,
    parameter int OUT_NUM_INT_W   = 4,
    parameter int OUT_NUM_FRACT_W = 10,
    localparam int IN_NUM_W  = IN_NUM_INT_W + IN_NUM_FRACT_W,
    localparam int OUT_NUM_W = OUT_NUM_INT_W + OUT_NUM_FRACT_W,
    localparam int REQ_IDX_W = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          i_start_pls,
    input  logic [N_REQ*IN_NUM_W-1:0] i_num_arr,
    input  logic                      i_clr_sat_cnt,
    output logic [N_REQ-1:0]          o_pend,
    output logic [N_REQ-1:0]          o_drop_pls,
    output logic [N_REQ-1:0]          o_done_pls,
    output logic [OUT_NUM_W-1:0]      o_num,
    output logic                      o_sat_hi,
    output logic                      o_sat_lo,
    output logic [15:0]               o_sat_cnt
);

    // Pre-saturation value carries the input integer bits and the output fraction bits.
    localparam int VW = IN_NUM_INT_W + OUT_NUM_FRACT_W;
    localparam int CW = ((VW > OUT_NUM_W) ? VW : OUT_NUM_W) + 1;
    localparam logic [OUT_NUM_W-1:0] OUT_MAX = {1'b0, {(OUT_NUM_W-1){1'b1}}};
    localparam logic [OUT_NUM_W-1:0] OUT_MIN = {1'b1, {(OUT_NUM_W-1){1'b0}}};
    localparam logic signed [CW-1:0] MAX_C = CW'($signed(OUT_MAX));
    localparam logic signed [CW-1:0] MIN_C = CW'($signed(OUT_MIN));

    logic [N_REQ-1:0]          r_pend;
    logic [N_REQ-1:0]          r_drop;
    logic [IN_NUM_W-1:0]       r_hold [N_REQ];
    logic [REQ_IDX_W-1:0]      r_ptr;
    logic                      r_v1;
    logic [IN_NUM_W-1:0]       r_op;
    logic [REQ_IDX_W-1:0]      r_idx1;
    logic                      r_v2;
    logic [REQ_IDX_W-1:0]      r_idx2;
    logic [OUT_NUM_W-1:0]      r_num;
    logic                      r_hi;
    logic                      r_lo;
    logic [15:0]               r_sat_cnt;

    logic                      w_gnt_vld;
    logic [REQ_IDX_W-1:0]      w_gnt_idx;
    logic [REQ_IDX_W-1:0]      w_cand;
    logic [N_REQ-1:0]          w_gnt_oh;
    logic [N_REQ-1:0]          w_accept;
    logic signed [VW-1:0]      w_val;
    logic signed [CW-1:0]      w_ext;
    logic                      w_hi;
    logic                      w_lo;
    logic [OUT_NUM_W-1:0]      w_num;

    // First pending requester after the last grant, wrapping around.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_cand = REQ_IDX_W'((int'(r_ptr) + 1 + i) % N_REQ);
            if (!w_gnt_vld && r_pend[w_cand]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    assign w_gnt_oh = w_gnt_vld ? (N_REQ'(1) << w_gnt_idx) : '0;
    assign w_accept = i_start_pls & (~r_pend | w_gnt_oh);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
            r_drop <= '0;
        end else begin
            r_drop <= i_start_pls & r_pend & ~w_gnt_oh;
            r_pend <= w_accept | (r_pend & ~w_gnt_oh);
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < N_REQ; k++) begin
            if (w_accept[k]) begin
                r_hold[k] <= i_num_arr[k*IN_NUM_W +: IN_NUM_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr  <= REQ_IDX_W'(N_REQ - 1);
            r_v1   <= 1'b0;
            r_op   <= '0;
            r_idx1 <= '0;
        end else begin
            r_v1 <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_op   <= r_hold[w_gnt_idx];
                r_idx1 <= w_gnt_idx;
                r_ptr  <= w_gnt_idx;
            end
        end
    end

    // Fraction alignment: widening zero-fills, narrowing drops LSBs (floor).
    generate
        if (OUT_NUM_FRACT_W == IN_NUM_FRACT_W) begin : g_same
            assign w_val = r_op;
        end else if (OUT_NUM_FRACT_W > IN_NUM_FRACT_W) begin : g_widen
            assign w_val = {r_op, {(OUT_NUM_FRACT_W-IN_NUM_FRACT_W){1'b0}}};
        end else begin : g_narrow
            logic w_unused_lsbs;
            assign w_val         = r_op[IN_NUM_W-1:IN_NUM_FRACT_W-OUT_NUM_FRACT_W];
            assign w_unused_lsbs = ^r_op[IN_NUM_FRACT_W-OUT_NUM_FRACT_W-1:0];
        end
    endgenerate

    assign w_ext = CW'(w_val);
    assign w_hi  = (w_ext > MAX_C);
    assign w_lo  = (w_ext < MIN_C);
    assign w_num = w_hi ? OUT_MAX : (w_lo ? OUT_MIN : w_ext[OUT_NUM_W-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2   <= 1'b0;
            r_idx2 <= '0;
            r_num  <= '0;
            r_hi   <= 1'b0;
            r_lo   <= 1'b0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_idx2 <= r_idx1;
                r_num  <= w_num;
                r_hi   <= w_hi;
                r_lo   <= w_lo;
            end
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all ones.
    always_ff @(posedge clk) begin
        if (rst || i_clr_sat_cnt) begin
            r_sat_cnt <= '0;
        end else if (r_v2 && (r_hi || r_lo) && (r_sat_cnt != 16'hFFFF)) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign o_pend     = r_pend;
    assign o_drop_pls = r_drop;
    assign o_done_pls = r_v2 ? (N_REQ'(1) << r_idx2) : '0;
    assign o_num      = r_num;
    assign o_sat_hi   = r_hi;
    assign o_sat_lo   = r_lo;
    assign o_sat_cnt  = r_sat_cnt;

endmodule
